// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared I/O constants for the switch debouncer and LED output block
package io_pkg;

    localparam int IO_WIDTH                = 24;
    localparam int DEBOUNCE_DIV_DEFAULT    = 50000;
    localparam int DEBOUNCE_STABLE_DEFAULT = 4;

    // Bits needed for a counter that must hold every value 0..max_val (never less than 1).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// rtl/sample_tick_gen.sv - free-running prescaler producing one sample tick every DIV clocks
module sample_tick_gen
    import io_pkg::*;
#(
    parameter int DIV = DEBOUNCE_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = cnt_width(DIV - 1);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_count;
    logic          w_wrap;

    // With DIV = 1 the count is pinned at 0 and the tick is permanently high.
    assign w_wrap = (r_count == LAST);
    assign tick   = w_wrap;

    // Count 0..DIV-1 and wrap back to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (w_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - per-bit synchronizer and sample-counting debouncer for board switches
module switch_debounce
    import io_pkg::*;
#(
    parameter int WIDTH  = IO_WIDTH,
    parameter int DIV    = DEBOUNCE_DIV_DEFAULT,
    parameter int STABLE = DEBOUNCE_STABLE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic             sw_event
);

    localparam int            CW       = cnt_width(STABLE);
    localparam logic [CW-1:0] LAST_CNT = CW'(STABLE - 1);

    logic             w_tick;
    logic [WIDTH-1:0] w_change;
    logic             r_sw_event;

    sample_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic          r_s1;
        logic          r_s2;
        logic          r_out;
        logic [CW-1:0] r_cnt;
        logic          w_differs;
        logic          w_settled;

        // The counter never passes STABLE-1: reaching it on a differing tick commits the bit.
        assign w_differs    = (r_s2 != r_out);
        assign w_settled    = (r_cnt == LAST_CNT);
        assign w_change[gi] = w_tick & w_differs & w_settled;
        assign sw_out[gi]   = r_out;

        // Two-flop synchronizer for the raw asynchronous switch.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_s1 <= 1'b0;
                r_s2 <= 1'b0;
            end else begin
                r_s1 <= sw_in[gi];
                r_s2 <= r_s1;
            end
        end

        // On each tick: count consecutive differing samples, drop glitches, commit when stable.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_cnt <= '0;
                r_out <= 1'b0;
            end else if (w_tick) begin
                if (!w_differs || w_settled) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                if (w_change[gi]) begin
                    r_out <= r_s2;
                end
            end
        end
    end

    // One strobe per output update, however many bits moved on that edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sw_event <= 1'b0;
        end else begin
            r_sw_event <= |w_change;
        end
    end

    assign sw_event = r_sw_event;

endmodule
